// File: rtl/gf2m_pkg.sv
// gf2m_pkg
// Shared definitions for the digit-serial GF(2^m) multiplier:
//   - gf2m_state_t : controller states (IDLE, CAL)
//   - ndig()       : number of D-bit digits needed to cover an M-bit operand
package gf2m_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CAL  = 1'b1
  } gf2m_state_t;

  // ceil(m/d): b is zero-extended at the MSB end to ndig*d bits.
  function automatic int ndig(input int m, input int d);
    return (m + d - 1) / d;
  endfunction

endpackage

// File: rtl/gf2m_mul_ds_digit_step.sv
// gf2m_digit_step
// Purely combinational Horner step over one D-bit digit of the multiplier:
//   for j = D-1 downto 0:  t = xtime(t); if (digit[j]) t ^= a
// where xtime is a multiply by x reduced modulo x^M + g.
// Ports:
//   t      in  M : running accumulator
//   a      in  M : multiplicand
//   digit  in  D : current multiplier digit, MSB processed first
//   g      in  M : reduction polynomial without the implicit x^M term
//   t_next out M : accumulator after the whole digit
module gf2m_digit_step #(
  parameter int M = 163,
  parameter int D = 16
) (
  input  logic [M-1:0] t,
  input  logic [M-1:0] a,
  input  logic [D-1:0] digit,
  input  logic [M-1:0] g,
  output logic [M-1:0] t_next
);

  // t_stage[i] is the accumulator after i inner iterations.
  logic [M-1:0] t_stage [D+1];

  assign t_stage[0] = t;

  generate
    for (genvar gi = 0; gi < D; gi++) begin : g_stage
      logic [M:0]   shifted;
      logic [M-1:0] xt;
      // Bit M of the shifted value is the coefficient that overflowed;
      // folding it back in means XOR-ing the low part of the polynomial.
      assign shifted = {t_stage[gi], 1'b0};
      assign xt      = shifted[M-1:0] ^ ({M{shifted[M]}} & g);
      assign t_stage[gi+1] = xt ^ ({M{digit[D-1-gi]}} & a);
    end
  endgenerate

  assign t_next = t_stage[D];

endmodule

// File: rtl/gf2m_mul_ds.sv
// gf2m_mul_ds
// Digit-serial GF(2^m) multiplier: result = a*b mod (x^M + g), one D-bit
// digit of b per clock, most significant digit first. Optional accumulate
// mode XORs the new product into the previous result.
// Ports:
//   clk    in  1 : rising-edge clock
//   rst    in  1 : asynchronous active-high reset
//   start  in  1 : operation request, sampled only while idle
//   acc    in  1 : sampled with start; 1 = result ^= product
//   a, b   in  M : operands (reduced, degree < M)
//   g      in  M : low M coefficients of the reduction polynomial
//   busy   out 1 : operation in progress (exactly NDIG cycles)
//   done   out 1 : one-cycle completion pulse
//   result out M : last result, held until the next completion
module gf2m_mul_ds
  import gf2m_pkg::*;
#(
  parameter int M = 163,
  parameter int D = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         acc,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic [M-1:0] g,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] result
);

  localparam int NDIG = ndig(M, D);
  localparam int BW   = NDIG * D;
  localparam int CW   = $clog2(NDIG + 1);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_CAL  = CAL;

  logic [0:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic [M-1:0]  a_reg;
  logic [M-1:0]  g_reg;
  logic [BW-1:0] b_reg;
  logic          acc_reg;
  logic [M-1:0]  t_reg;
  logic [M-1:0]  result_reg;
  logic          done_reg;

  logic [BW-1:0] b_pad;
  logic [D-1:0]  digit;
  logic [M-1:0]  t_next;
  logic          last_digit;

  assign b_pad      = BW'(b);
  assign digit      = b_reg[BW-1 -: D];
  assign last_digit = (cnt_reg == CW'(NDIG - 1));

  gf2m_digit_step #(
    .M (M),
    .D (D)
  ) u_step (
    .t      (t_reg),
    .a      (a_reg),
    .digit  (digit),
    .g      (g_reg),
    .t_next (t_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      a_reg      <= '0;
      g_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= 1'b0;
      t_reg      <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            a_reg     <= a;
            g_reg     <= g;
            b_reg     <= b_pad;
            acc_reg   <= acc;
            t_reg     <= '0;
            cnt_reg   <= '0;
            state_reg <= ST_CAL;
          end
        end
        ST_CAL: begin
          t_reg   <= t_next;
          b_reg   <= b_reg << D;
          cnt_reg <= cnt_reg + CW'(1);
          if (last_digit) begin
            // Use t_next directly so the result lands on the final edge.
            result_reg <= t_next ^ (acc_reg ? result_reg : '0);
            done_reg   <= 1'b1;
            state_reg  <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (state_reg == ST_CAL);
  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_gf2m_mul_ds.sv
// tb_gf2m_mul_ds
// Directed bench for gf2m_mul_ds with three configurations:
//   u8d4  : M=8,   D=4  (AES field, g=0x1B)
//   u8d3  : M=8,   D=3  (digit width not dividing M)
//   u163  : M=163, D=16 (NIST B-163 style polynomial)
module tb_gf2m_mul_ds;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // M=8, D=4
  logic        p_start, p_acc, p_busy, p_done;
  logic [7:0]  p_a, p_b, p_g, p_res;
  // M=8, D=3
  logic        q_start, q_acc, q_busy, q_done;
  logic [7:0]  q_a, q_b, q_g, q_res;
  // M=163, D=16
  logic          w_start, w_acc, w_busy, w_done;
  logic [162:0]  w_a, w_b, w_g, w_res;

  int checks = 0;
  int errors = 0;
  int lat;

  gf2m_mul_ds #(.M(8), .D(4)) u8d4 (
    .clk(clk), .rst(rst), .start(p_start), .acc(p_acc), .a(p_a), .b(p_b),
    .g(p_g), .busy(p_busy), .done(p_done), .result(p_res)
  );

  gf2m_mul_ds #(.M(8), .D(3)) u8d3 (
    .clk(clk), .rst(rst), .start(q_start), .acc(q_acc), .a(q_a), .b(q_b),
    .g(q_g), .busy(q_busy), .done(q_done), .result(q_res)
  );

  gf2m_mul_ds #(.M(163), .D(16)) u163 (
    .clk(clk), .rst(rst), .start(w_start), .acc(w_acc), .a(w_a), .b(w_b),
    .g(w_g), .busy(w_busy), .done(w_done), .result(w_res)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [162:0] obs, input logic [162:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    p_start = 0; p_acc = 0; p_a = 0; p_b = 0; p_g = 8'h1B;
    q_start = 0; q_acc = 0; q_a = 0; q_b = 0; q_g = 8'h1B;
    w_start = 0; w_acc = 0; w_a = '0; w_b = '0; w_g = 163'hC9;

    // Reset state
    tick; tick;
    chk("rst_busy", p_busy, 0);
    chk("rst_done", p_done, 0);
    chk("rst_res8", p_res, 0);
    chk("rst_res163", w_res, 0);
    rst = 0;
    tick;

    // 0x57 * 0x83 = 0xC1, latency 2
    p_start = 1; p_acc = 0; p_a = 8'h57; p_b = 8'h83;
    tick; p_start = 0;
    chk("op1_busy_c1", p_busy, 1);
    chk("op1_done_c1", p_done, 0);
    tick;
    chk("op1_busy_c2", p_busy, 1);
    chk("op1_done_c2", p_done, 0);
    tick;
    chk("op1_done", p_done, 1);
    chk("op1_busy_end", p_busy, 0);
    chk("op1_res", p_res, 8'hC1);
    $display("op1 a=57 b=83 acc=0 result=%02h", p_res);

    // Back-to-back in done cycle, accumulate: 0xC1 ^ (0x57*0x13=0xFE) = 0x3F
    p_start = 1; p_acc = 1; p_a = 8'h57; p_b = 8'h13;
    tick; p_start = 0; p_acc = 0;
    chk("op2_accepted", p_busy, 1);
    chk("op2_done_low", p_done, 0);
    chk("op2_res_held", p_res, 8'hC1);
    tick;
    chk("op2_busy_c2", p_busy, 1);
    tick;
    chk("op2_done", p_done, 1);
    chk("op2_res", p_res, 8'h3F);
    $display("op2 a=57 b=13 acc=1 result=%02h", p_res);

    // start during busy is ignored
    tick;
    p_start = 1; p_a = 8'h57; p_b = 8'h83;
    tick;
    p_start = 1; p_acc = 1; p_a = 8'h02; p_b = 8'h02;
    tick; p_start = 0; p_acc = 0;
    chk("ign_busy", p_busy, 1);
    chk("ign_done_low", p_done, 0);
    tick;
    chk("ign_done", p_done, 1);
    chk("ign_res", p_res, 8'hC1);
    tick;
    chk("ign_no_2nd_done", p_done, 0);
    chk("ign_idle", p_busy, 0);
    tick;
    chk("ign_no_2nd_done_b", p_done, 0);
    chk("ign_res_hold", p_res, 8'hC1);
    $display("ignore-during-busy result=%02h", p_res);

    // Reset at digit 1 of 2
    p_start = 1; p_a = 8'h57; p_b = 8'h83;
    tick; p_start = 0;
    tick;
    rst = 1;
    #1;
    chk("abort_busy", p_busy, 0);
    chk("abort_done", p_done, 0);
    chk("abort_res", p_res, 0);
    tick;
    chk("abort_done_hold", p_done, 0);
    rst = 0;
    tick;
    chk("abort_done_after", p_done, 0);
    chk("abort_res_after", p_res, 0);
    p_start = 1; p_a = 8'h57; p_b = 8'h83;
    tick; p_start = 0;
    lat = 0;
    while (!p_done && lat < 20) begin tick; lat++; end
    chk("post_rst_lat", lat, 2);
    chk("post_rst_res", p_res, 8'hC1);
    $display("post-reset op result=%02h latency=%0d", p_res, lat);

    // Non-divisible digit width: NDIG=3
    q_start = 1; q_a = 8'h57; q_b = 8'h83;
    tick; q_start = 0;
    lat = 0;
    while (!q_done && lat < 20) begin tick; lat++; end
    chk("d3_lat", lat, 3);
    chk("d3_res", q_res, 8'hC1);
    $display("D=3 op result=%02h latency=%0d", q_res, lat);

    // M=163: 1 * b = b, latency 11
    w_start = 1; w_a = 163'h1;
    w_b = 163'h5_0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C;
    tick; w_start = 0;
    lat = 0;
    while (!w_done && lat < 40) begin tick; lat++; end
    chk("m163_lat", lat, 11);
    chk("m163_id", w_res, 163'h5_0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C);
    $display("M=163 a=1 result=%0h latency=%0d", w_res, lat);

    // x^162 * x = x^163 = g
    w_a = '0; w_a[162] = 1'b1; w_b = 163'h2;
    w_start = 1;
    tick; w_start = 0;
    lat = 0;
    while (!w_done && lat < 40) begin tick; lat++; end
    chk("m163_wrap_lat", lat, 11);
    chk("m163_wrap", w_res, 163'hC9);
    $display("M=163 x^162*x result=%0h", w_res);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
